// File: rtl/calf_inject_ni_pkg.sv
// Shared definitions for the CALF injection network interface: flit field
// layout, the queued request record, FSM states and the flit formatter.
package calf_inject_ni_pkg;

  localparam int CONTROL_W = 144;

  localparam int DEST_LSB  = 0;
  localparam int DEST_W    = 4;
  localparam int SRC_LSB   = 4;
  localparam int SRC_W     = 4;
  localparam int SEQ_LSB   = 8;
  localparam int SEQ_W     = 3;
  localparam int VALID_BIT = 11;
  localparam int MSHR_LSB  = 12;
  localparam int MSHR_W    = 4;
  localparam int DATA_LSB  = 16;
  localparam int DATA_W    = 128;

  // One queued request: {last, mshr, dest, data} = 137 bits.
  typedef struct packed {
    logic              last;
    logic [MSHR_W-1:0] mshr;
    logic [DEST_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } req_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } state_t;

  // Build the router-facing flit from a queued request.
  function automatic logic [CONTROL_W-1:0] format_flit(
    input req_t             r,
    input logic [SRC_W-1:0] src,
    input logic [SEQ_W-1:0] seq
  );
    logic [CONTROL_W-1:0] f;
    f                        = '0;
    f[DEST_LSB +: DEST_W]    = r.dest;
    f[SRC_LSB  +: SRC_W]     = src;
    f[SEQ_LSB  +: SEQ_W]     = seq;
    f[VALID_BIT]             = 1'b1;
    f[MSHR_LSB +: MSHR_W]    = r.mshr;
    f[DATA_LSB +: DATA_W]    = r.data;
    return f;
  endfunction

endpackage

// File: rtl/calf_inject_ni_if.sv
// Node request channel plus router injection port, bundled as one interface.
interface calf_inject_ni_if;

  logic                                 in_valid;
  logic                                 in_ready;
  logic [3:0]                           in_dest;
  logic [3:0]                           in_mshr;
  logic                                 in_last;
  logic [127:0]                         in_data;
  logic [calf_inject_ni_pkg::CONTROL_W-1:0] port4_ci;
  logic                                 port4_ready;
  logic                                 port4_ack;

  // Environment side: the node issuing requests and the router answering.
  modport master (
    output in_valid, in_dest, in_mshr, in_last, in_data, port4_ready, port4_ack,
    input  in_ready, port4_ci
  );

  // Network-interface side.
  modport slave (
    input  in_valid, in_dest, in_mshr, in_last, in_data, port4_ready, port4_ack,
    output in_ready, port4_ci
  );

endinterface

// File: rtl/calf_ni_fifo.sv
// Request FIFO: DEPTH entries of req_t with full/empty/count. Exposes the
// head and the entry behind it so the top can offer flits back-to-back.
module calf_ni_fifo
  import calf_inject_ni_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  req_t        wdata,
  output req_t        head,
  output req_t        head_next,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);

  req_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_ptr_next;

  assign rd_ptr_next = rd_ptr + 1'b1;
  assign head        = mem[rd_ptr];
  assign head_next   = mem[rd_ptr_next];
  assign full        = (count == (AW+1)'(DEPTH));
  assign empty       = (count == '0);

  // Storage write.
  // NOTE: the array has no reset; stale contents are never observed because
  // count gates every read, and leaving it unreset keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr_next;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/calf_inject_ni.sv
// CALF injection network interface: queues node requests, formats them into
// flits with in-packet sequence numbers, offers them on the router's
// injection port until acked, and keeps injection/stall statistics.
module calf_inject_ni
  import calf_inject_ni_pkg::*;
#(
  parameter logic [3:0] NODE_ID = 4'd5,
  parameter int         DEPTH   = 4,
  parameter int         CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  calf_inject_ni_if.slave      bus,
  output logic                 busy,
  output logic [CNT_W-1:0]     inj_cnt,
  output logic [CNT_W-1:0]     stall_cnt
);

  localparam int AW = $clog2(DEPTH);

  state_t               state;
  logic [SEQ_W-1:0]     seq;
  logic [SEQ_W-1:0]     seq_next;
  logic [CONTROL_W-1:0] ci_q;
  logic                 ready_q;

  req_t        wr_req;
  req_t        head;
  req_t        head_next;
  logic        full;
  logic        empty;
  logic [AW:0] count;
  logic        push;
  logic        pop;
  logic        more;

  assign wr_req = '{last: bus.in_last, mshr: bus.in_mshr,
                    dest: bus.in_dest, data: bus.in_data};

  // in_ready stays low through reset and rises on the first edge after release.
  assign bus.in_ready = ready_q & ~full;
  assign push         = bus.in_valid & bus.in_ready;
  assign pop          = (state == ST_OFFER) & bus.port4_ack;
  assign more         = (count > (AW+1)'(1));
  assign seq_next     = head.last ? '0 : seq + 1'b1;
  assign bus.port4_ci = ci_q;
  assign busy         = (state == ST_OFFER) | ~empty;

  calf_ni_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .wdata     (wr_req),
    .head      (head),
    .head_next (head_next),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  // Post-reset flag that enables the request channel.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ready_q <= 1'b0;
    else      ready_q <= 1'b1;
  end

  // Offer FSM with output register, sequence number and statistics.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      ci_q      <= '0;
      seq       <= '0;
      inj_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!empty && bus.port4_ready) begin
            state <= ST_OFFER;
            ci_q  <= format_flit(head, NODE_ID, seq);
          end else begin
            ci_q  <= '0;
          end
        end
        ST_OFFER: begin
          if (bus.port4_ack) begin
            seq     <= seq_next;
            inj_cnt <= inj_cnt + 1'b1;
            if (more && bus.port4_ready) begin
              ci_q  <= format_flit(head_next, NODE_ID, seq_next);
            end else begin
              state <= ST_IDLE;
              ci_q  <= '0;
            end
          end else if (stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calf_inject_ni.sv
// Self-checking bench for calf_inject_ni: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// queue-based model of the injection interface.
module tb_calf_inject_ni;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic        busy;
  logic [15:0] inj_cnt;
  logic [15:0] stall_cnt;

  int checks   = 0;
  int failures = 0;

  calf_inject_ni_if bus();

  calf_inject_ni #(.NODE_ID(4'd5), .DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .inj_cnt   (inj_cnt),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    logic [3:0]   dest;
    logic [3:0]   mshr;
    logic         last;
    logic [127:0] data;
  } ent_t;

  ent_t         q[$];
  bit           m_off   = 0;
  logic [143:0] m_ci    = '0;
  int           m_seq   = 0;
  logic [15:0]  m_inj   = '0;
  logic [15:0]  m_stall = '0;
  bit           m_rdy   = 0;
  bit           m_push;
  ent_t         m_new;

  function automatic logic [143:0] exp_flit(ent_t e, int s);
    logic [2:0] s3;
    s3 = s[2:0];
    return {e.data, e.mshr, 1'b1, s3, 4'd5, e.dest};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      m_off = 0; m_ci = '0; m_seq = 0; m_inj = '0; m_stall = '0; m_rdy = 0;
    end else begin
      m_push = bus.in_valid && m_rdy && (q.size() < DEPTH);
      m_new  = '{dest: bus.in_dest, mshr: bus.in_mshr, last: bus.in_last, data: bus.in_data};
      if (!m_off) begin
        if (q.size() > 0 && bus.port4_ready) begin
          m_off = 1;
          m_ci  = exp_flit(q[0], m_seq);
        end else begin
          m_ci = '0;
        end
      end else if (bus.port4_ack) begin
        m_seq = q[0].last ? 0 : (m_seq + 1) % 8;
        void'(q.pop_front());
        m_inj = m_inj + 16'd1;
        if (q.size() > 0 && bus.port4_ready) begin
          m_ci = exp_flit(q[0], m_seq);
        end else begin
          m_off = 0;
          m_ci  = '0;
        end
      end else if (m_stall != 16'hFFFF) begin
        m_stall = m_stall + 16'd1;
      end
      if (m_push) q.push_back(m_new);
      m_rdy = 1;
    end
  end

  task automatic check(input string name, input logic [143:0] act, input logic [143:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare, sampled on the falling edge.
  always @(negedge clk) begin
    check("in_ready",  144'(bus.in_ready), 144'(m_rdy && (q.size() < DEPTH)));
    check("port4_ci",  bus.port4_ci, m_ci);
    check("busy",      144'(busy), 144'(m_off || (q.size() > 0)));
    check("inj_cnt",   144'(inj_cnt), 144'(m_inj));
    check("stall_cnt", 144'(stall_cnt), 144'(m_stall));
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_req(input logic v, input logic [3:0] d, input logic [3:0] m,
                         input logic l, input logic [127:0] data);
    bus.in_valid = v; bus.in_dest = d; bus.in_mshr = m; bus.in_last = l; bus.in_data = data;
  endtask

  function automatic logic [127:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  logic [127:0] d0;
  logic [143:0] held;
  logic [15:0]  inj_save;

  initial begin
    set_req(1'b0, 4'd0, 4'd0, 1'b0, '0);
    bus.port4_ready = 1'b0;
    bus.port4_ack   = 1'b0;
    #1 rst = 1'b0;
    step(3);
    check("rst_ci",       bus.port4_ci, '0);
    check("rst_in_ready", 144'(bus.in_ready), 144'(0));
    rst = 1'b1;
    step(1);
    check("in_ready_after_release", 144'(bus.in_ready), 144'(1));

    // 1: single-flit packet, header and payload after two edges.
    d0 = rand_data();
    bus.port4_ready = 1'b1;
    set_req(1'b1, 4'd7, 4'd1, 1'b1, d0);
    step(1);
    bus.in_valid = 1'b0;
    step(1);
    check("t1_header", 144'(bus.port4_ci[15:0]), 144'(16'h1857));
    check("t1_data",   144'(bus.port4_ci[143:16]), 144'(d0));
    bus.port4_ack = 1'b1;
    step(1);
    bus.port4_ack = 1'b0;
    check("t1_ci_cleared", bus.port4_ci, '0);
    check("t1_inj_cnt",    144'(inj_cnt), 144'(1));

    // 2: two-flit packet then one-flit packet, acked every cycle.
    bus.port4_ack = 1'b1;
    set_req(1'b1, 4'd7, 4'd1, 1'b0, rand_data());
    step(1);
    set_req(1'b1, 4'd7, 4'd1, 1'b1, rand_data());
    step(1);
    check("t2_hdr0", 144'(bus.port4_ci[15:0]), 144'(16'h1857));
    set_req(1'b1, 4'd7, 4'd1, 1'b1, rand_data());
    step(1);
    bus.in_valid = 1'b0;
    check("t2_hdr1", 144'(bus.port4_ci[15:0]), 144'(16'h1957));
    step(1);
    check("t2_hdr2", 144'(bus.port4_ci[15:0]), 144'(16'h1857));
    step(2);
    bus.port4_ack = 1'b0;
    check("t2_inj_cnt", 144'(inj_cnt), 144'(4));

    // 3: no slot for five cycles, then an offer stalled for three cycles.
    bus.port4_ready = 1'b0;
    set_req(1'b1, 4'd2, 4'd3, 1'b1, rand_data());
    step(1);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("t3_idle_ci", bus.port4_ci, '0);
    end
    bus.port4_ready = 1'b1;
    step(1);
    held = bus.port4_ci;
    check("t3_offer_valid", 144'(held[11]), 144'(1));
    for (int i = 0; i < 3; i++) begin
      bus.port4_ready = i[0];
      step(1);
      check("t3_hold", bus.port4_ci, held);
    end
    bus.port4_ack = 1'b1;
    step(1);
    bus.port4_ack = 1'b0;
    check("t3_stall_cnt", 144'(stall_cnt), 144'(3));

    // 4: fill the FIFO, then pop once; in_ready recovers only after the pop.
    bus.port4_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      set_req(1'b1, 4'(i), 4'd0, 1'b1, rand_data());
      check("t4_ready_fill", 144'(bus.in_ready), 144'(1));
      step(1);
    end
    check("t4_full", 144'(bus.in_ready), 144'(0));
    bus.port4_ready = 1'b1;
    step(1);
    check("t4_full_offer", 144'(bus.in_ready), 144'(0));
    bus.port4_ack = 1'b1;
    check("t4_no_ready_during_pop", 144'(bus.in_ready), 144'(0));
    step(1);
    check("t4_ready_after_pop", 144'(bus.in_ready), 144'(1));
    bus.in_valid = 1'b0;
    step(4);
    bus.port4_ack = 1'b0;
    check("t4_drained", 144'(busy), 144'(0));

    // 5: reset while offering a seq=1 flit.
    set_req(1'b1, 4'd4, 4'd0, 1'b0, rand_data());
    step(1);
    bus.in_valid = 1'b0;
    step(1);
    bus.port4_ack = 1'b1;
    step(1);
    bus.port4_ack = 1'b0;
    set_req(1'b1, 4'd4, 4'd0, 1'b1, rand_data());
    step(1);
    bus.in_valid = 1'b0;
    step(1);
    check("t5_seq1", 144'(bus.port4_ci[10:8]), 144'(1));
    #2 rst = 1'b0;
    #1;
    check("t5_rst_ci",    bus.port4_ci, '0);
    check("t5_rst_busy",  144'(busy), 144'(0));
    check("t5_rst_inj",   144'(inj_cnt), 144'(0));
    check("t5_rst_stall", 144'(stall_cnt), 144'(0));
    step(2);
    rst = 1'b1;
    step(1);
    set_req(1'b1, 4'd3, 4'd2, 1'b1, rand_data());
    step(1);
    bus.in_valid = 1'b0;
    step(1);
    check("t5_seq0_header", 144'(bus.port4_ci[15:0]), 144'(16'h2853));
    bus.port4_ack = 1'b1;
    step(1);
    bus.port4_ack = 1'b0;
    check("t5_inj", 144'(inj_cnt), 144'(1));

    // 6: ack in IDLE with an empty FIFO is ignored.
    inj_save = inj_cnt;
    bus.port4_ack = 1'b1;
    step(2);
    bus.port4_ack = 1'b0;
    check("t6_inj", 144'(inj_cnt), 144'(inj_save));
    check("t6_ci",  bus.port4_ci, '0);
    set_req(1'b1, 4'd7, 4'd1, 1'b1, rand_data());
    step(1);
    bus.in_valid = 1'b0;
    step(1);
    check("t6_seq_unchanged", 144'(bus.port4_ci[15:0]), 144'(16'h1857));
    bus.port4_ack = 1'b1;
    step(1);

    // Randomized traffic with one asynchronous reset pulse.
    for (int c = 0; c < 3000; c++) begin
      set_req($urandom_range(0, 99) < 60, 4'($urandom), 4'($urandom),
              $urandom_range(0, 2) == 0, rand_data());
      bus.port4_ready = $urandom_range(0, 99) < 70;
      bus.port4_ack   = $urandom_range(0, 99) < 50;
      if (c == 1500) begin
        #2 rst = 1'b0;
        step(2);
        rst = 1'b1;
      end
      step(1);
    end

    bus.in_valid = 1'b0;
    bus.port4_ready = 1'b1;
    bus.port4_ack = 1'b1;
    step(DEPTH + 3);
    check("final_idle", 144'(busy), 144'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
